sn_api_scheduler: RTL and testbench

SN_API_SCHEDULER -- requirements
Module: sn_api_scheduler

---
 rtl/sn_pkg.sv | 24 ++
 rtl/sn_rr_arbiter.sv | 31 +++
 rtl/sn_api_scheduler.sv | 117 +++++++++++
 tb/tb_sn_api_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sn_pkg.sv
// Shared types and size helpers for the spiking-network bus scheduler.
// The requester count and pointer width are derived from the network size.
package sn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NRST,
    ST_SETTLE,
    ST_TRANSMIT,
    ST_EVAL,
    ST_DONE
  } sn_state_e;

  // Output-layer neurons never transmit, so they are not bus requesters.
  function automatic int calc_n_req(input int num_neurons, input int num_outputs);
    return num_neurons - num_outputs;
  endfunction

  // Held at a minimum of 1 so the pointer stays a legal vector when there is a single requester.
  function automatic int calc_ptr_bw(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/sn_rr_arbiter.sv
// Circular priority search: grants the first set request at or after ptr.
// Purely combinational; the caller owns the pointer register.
module sn_rr_arbiter #(
  parameter int N_REQ  = 97,
  parameter int PTR_BW = 7
) (
  input  logic [N_REQ-1:0]  req,
  input  logic [PTR_BW-1:0] ptr,
  output logic [N_REQ-1:0]  gnt,
  output logic [PTR_BW-1:0] gnt_idx,
  output logic              any
);

  always_comb begin
    int w_idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = PTR_BW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/sn_api_scheduler.sv
// Timestep scheduler for a spiking-network core: resets the neurons, lets every
// pending neuron transmit once per step via round-robin grant, then evaluates.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; outputs low, requests ignored
// NRST     | one-cycle neuron-core reset pulse
// SETTLE   | one quiet cycle before the transmit window
// TRANSMIT | one grant per cycle until no requester is pending
// EVAL     | one-cycle neuron evaluate pulse, step counter advances
// DONE     | one-cycle done pulse, then back to IDLE
module sn_api_scheduler
  import sn_pkg::*;
#(
  parameter int  P_NUM_NEURONS       = 100,
  parameter int  P_NUM_OUTPUTS       = 3,
  parameter int  P_NEUR_STEP_CNTR_BW = 7,
  localparam int N_REQ               = calc_n_req(P_NUM_NEURONS, P_NUM_OUTPUTS),
  localparam int PTR_BW              = calc_ptr_bw(N_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [P_NEUR_STEP_CNTR_BW-1:0] num_steps,
  input  logic [N_REQ-1:0]               api_pending,
  output logic [N_REQ-1:0]               api_granted,
  output logic                           api_vld,
  output logic                           nc_reset,
  output logic                           nc_evaluate,
  output logic                           busy,
  output logic                           done,
  output logic [P_NEUR_STEP_CNTR_BW-1:0] step_cnt
);

  sn_state_e                      r_state;
  sn_state_e                      w_next;
  logic [P_NEUR_STEP_CNTR_BW-1:0] r_num_steps;
  logic [P_NEUR_STEP_CNTR_BW-1:0] r_step_cnt;
  logic [P_NEUR_STEP_CNTR_BW-1:0] w_step_inc;
  logic [PTR_BW-1:0]              r_rr_ptr;
  logic [N_REQ-1:0]               w_gnt;
  logic [PTR_BW-1:0]              w_gnt_idx;
  logic                           w_any;

  sn_rr_arbiter #(
    .N_REQ  (N_REQ),
    .PTR_BW (PTR_BW)
  ) u_arb (
    .req     (api_pending),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign w_step_inc = r_step_cnt + P_NEUR_STEP_CNTR_BW'(1);
  assign step_cnt   = r_step_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:     if (start) w_next = ST_NRST;
      ST_NRST:     w_next = (r_num_steps == '0) ? ST_DONE : ST_SETTLE;
      ST_SETTLE:   w_next = ST_TRANSMIT;
      ST_TRANSMIT: if (!w_any) w_next = ST_EVAL;
      ST_EVAL:     w_next = (w_step_inc == r_num_steps) ? ST_DONE : ST_SETTLE;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    api_granted = '0;
    api_vld     = 1'b0;
    nc_reset    = 1'b0;
    nc_evaluate = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    unique case (r_state)
      ST_IDLE:     busy = 1'b0;
      ST_NRST:     nc_reset = 1'b1;
      ST_TRANSMIT: begin
        api_granted = w_gnt;
        api_vld     = w_any;
      end
      ST_EVAL:     nc_evaluate = 1'b1;
      ST_DONE:     done = 1'b1;
      default:     ;
    endcase
  end

  // The pointer is deliberately left alone between steps and runs so that
  // low-index neurons cannot starve the rest across timesteps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_steps <= '0;
      r_step_cnt  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_num_steps <= num_steps;
        r_step_cnt  <= '0;
      end
      if (r_state == ST_EVAL) r_step_cnt <= w_step_inc;
      if (r_state == ST_TRANSMIT && w_any) begin
        if (w_gnt_idx == PTR_BW'(N_REQ - 1)) r_rr_ptr <= '0;
        else                                 r_rr_ptr <= w_gnt_idx + PTR_BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sn_api_scheduler.sv
// Self-checking bench for sn_api_scheduler: a per-cycle expectation timeline is
// built from the scheduling rules, then replayed against the DUT.
module tb_sn_api_scheduler;

  localparam int N  = 97;
  localparam int BW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [BW-1:0] num_steps;
  logic [N-1:0]  api_pending;
  logic [N-1:0]  api_granted;
  logic          api_vld;
  logic          nc_reset;
  logic          nc_evaluate;
  logic          busy;
  logic          done;
  logic [BW-1:0] step_cnt;

  always #5 clk = ~clk;

  sn_api_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_steps   (num_steps),
    .api_pending (api_pending),
    .api_granted (api_granted),
    .api_vld     (api_vld),
    .nc_reset    (nc_reset),
    .nc_evaluate (nc_evaluate),
    .busy        (busy),
    .done        (done),
    .step_cnt    (step_cnt)
  );

  typedef struct {
    logic [N-1:0]  raise;
    logic          start;
    logic [BW-1:0] nsteps;
    int            gidx;
    logic          nrst;
    logic          neval;
    logic          done;
    logic          busy;
    logic [BW-1:0] scnt;
  } cyc_t;

  typedef struct {
    int           steps;
    logic [N-1:0] pend;
    int           first;
    int           last;
    int           cnt;
  } scen_t;

  cyc_t         exp_q[$];
  scen_t        tbl[5];
  int           checks = 0;
  int           errors = 0;
  int           m_ptr  = 0;
  int           m_scnt = 0;
  bit           inj    = 1'b0;
  logic [N-1:0] pend   = '0;
  logic [N-1:0] step_pend[8];
  int           obs_cnt, obs_first, obs_last, obs_evals, obs_done;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic cyc_t mk(input int scnt, input logic bsy);
    cyc_t r;
    r.raise  = '0;
    r.start  = inj;
    r.nsteps = inj ? BW'(7) : '0;
    r.gidx   = -1;
    r.nrst   = 1'b0;
    r.neval  = 1'b0;
    r.done   = 1'b0;
    r.busy   = bsy;
    r.scnt   = BW'(scnt);
    return r;
  endfunction

  // Timeline: start, reset pulse, then per step settle / grants / empty window / evaluate, then done.
  task automatic build_run(input int S, input bit inject);
    cyc_t r, t;
    int   order[$];
    inj = 1'b0;
    r = mk(m_scnt, 1'b0);
    r.start  = 1'b1;
    r.nsteps = BW'(S);
    exp_q.push_back(r);
    inj    = inject;
    m_scnt = 0;
    r = mk(0, 1'b1);
    r.nrst = 1'b1;
    exp_q.push_back(r);
    for (int s = 0; s < S; s++) begin
      r = mk(s, 1'b1);
      if ($urandom_range(1) == 1) begin
        t = exp_q.pop_back();
        t.raise = t.raise | step_pend[s];
        exp_q.push_back(t);
      end else begin
        r.raise = step_pend[s];
      end
      exp_q.push_back(r);
      order.delete();
      for (int k = 0; k < N; k++) begin
        if (step_pend[s][(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
      end
      foreach (order[j]) begin
        r = mk(s, 1'b1);
        r.gidx = order[j];
        exp_q.push_back(r);
      end
      if (order.size() > 0) m_ptr = (order[order.size()-1] + 1) % N;
      exp_q.push_back(mk(s, 1'b1));
      r = mk(s, 1'b1);
      r.neval = 1'b1;
      exp_q.push_back(r);
    end
    m_scnt = S;
    r = mk(S, 1'b1);
    r.done = 1'b1;
    exp_q.push_back(r);
    inj = 1'b0;
  endtask

  task automatic exec_q();
    cyc_t         r;
    logic [N-1:0] last_g, eg;
    int           gi;
    last_g    = '0;
    obs_cnt   = 0;
    obs_first = -1;
    obs_last  = -1;
    obs_evals = 0;
    obs_done  = 0;
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      @(posedge clk); #1;
      pend        = (pend & ~last_g) | r.raise;
      api_pending = pend;
      start       = r.start;
      num_steps   = r.nsteps;
      #1;
      eg = '0;
      if (r.gidx >= 0) eg[r.gidx] = 1'b1;
      chk("api_granted", api_granted, eg);
      chk("api_vld", api_vld, r.gidx >= 0);
      chk("nc_reset", nc_reset, r.nrst);
      chk("nc_evaluate", nc_evaluate, r.neval);
      chk("done", done, r.done);
      chk("busy", busy, r.busy);
      chk("step_cnt", step_cnt, r.scnt);
      chk("onehot", $countones(api_granted) <= 1, 1'b1);
      last_g = api_granted;
      if (api_vld) begin
        gi = -1;
        for (int i = 0; i < N; i++) if (api_granted[i]) gi = i;
        if (obs_cnt == 0) obs_first = gi;
        obs_last = gi;
        obs_cnt++;
      end
      obs_evals += int'(nc_evaluate);
      obs_done  += int'(done);
    end
    start     = 1'b0;
    num_steps = '0;
  endtask

  task automatic clear_steps();
    for (int s = 0; s < 8; s++) step_pend[s] = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] v;
    logic [N-1:0] bits;
    bit           found;

    tbl[0] = '{steps: 3, pend: '0, first: -1, last: -1, cnt: 0};
    v = '0; v[2] = 1'b1; v[5] = 1'b1; v[96] = 1'b1;
    tbl[1] = '{steps: 1, pend: v, first: 2, last: 96, cnt: 3};
    v = '0; v[5] = 1'b1;
    tbl[2] = '{steps: 1, pend: v, first: 5, last: 5, cnt: 1};
    tbl[3] = '{steps: 1, pend: '1, first: 6, last: 5, cnt: 97};
    tbl[4] = '{steps: 0, pend: '0, first: -1, last: -1, cnt: 0};

    rst = 1'b1; start = 1'b0; num_steps = '0; api_pending = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; #1;
    chk("rst_granted", api_granted, '0);
    chk("rst_vld", api_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_nc", {nc_reset, nc_evaluate}, 2'b00);
    chk("rst_step_cnt", step_cnt, '0);

    for (int i = 0; i < 5; i++) begin
      clear_steps();
      step_pend[0] = tbl[i].pend;
      build_run(tbl[i].steps, 1'b0);
      exec_q();
      chk("sc_first", obs_first, tbl[i].first);
      chk("sc_last", obs_last, tbl[i].last);
      chk("sc_grants", obs_cnt, tbl[i].cnt);
      chk("sc_evals", obs_evals, tbl[i].steps);
      chk("sc_done", obs_done, 1);
    end

    for (int run = 0; run < 8; run++) begin
      int S;
      S = $urandom_range(1, 4);
      clear_steps();
      for (int s = 0; s < S; s++) begin
        v = '0;
        if ($urandom_range(4) != 0)
          for (int i = 0; i < N; i++) if ($urandom_range(15) == 0) v[i] = 1'b1;
        step_pend[s] = v;
      end
      build_run(S, 1'b0);
      exec_q();
      chk("rnd_evals", obs_evals, S);
      chk("rnd_done", obs_done, 1);
    end

    // Abort in the middle of the second step's transmit window.
    bits = '0; bits[10] = 1'b1; bits[20] = 1'b1; bits[30] = 1'b1;
    pend = '0;
    @(posedge clk); #1;
    start = 1'b1; num_steps = BW'(5); api_pending = '0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (step_cnt == BW'(1)) api_pending = bits;
      #1;
      if (api_vld) found = 1'b1;
    end
    chk("abort_reached_transmit", found, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("abort_granted", api_granted, '0);
    chk("abort_vld", api_vld, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_nc", {nc_reset, nc_evaluate}, 2'b00);
    chk("abort_step_cnt", step_cnt, '0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      chk("idle_granted", api_granted, '0);
      chk("idle_done", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end
    api_pending = '0;
    m_ptr  = 0;
    m_scnt = 0;
    clear_steps();
    step_pend[2] = bits;
    build_run(5, 1'b0);
    exec_q();
    chk("rerun_evals", obs_evals, 5);
    chk("rerun_done", obs_done, 1);
    chk("rerun_first", obs_first, 10);

    // start held high for the whole run must not reload the step target.
    clear_steps();
    v = '0; v[40] = 1'b1; v[3] = 1'b1;
    step_pend[1] = v;
    build_run(2, 1'b1);
    exec_q();
    chk("busy_start_evals", obs_evals, 2);
    chk("busy_start_done", obs_done, 1);
    chk("busy_start_grants", obs_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
